// File: rtl/button_counter.sv
// Two debounced push buttons driving an up/down counter with wrap and overflow pulse.
// Saturating limits instead of wrap when BUTTON_COUNTER_SAT_EN is defined.
module button_counter #(
  parameter int                 WIDTH           = 8,
  parameter int                 DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0]   INIT            = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             press_inc,
  output logic             press_dec,
  output logic             ovf
);

  localparam int               CW   = $clog2(DEBOUNCE_CYCLES + 1);
  // cnt holds samples already seen; the sample that makes it DEBOUNCE_CYCLES completes the wait
  localparam logic [CW-1:0]    LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [1:0] btn;
  logic [1:0] accept;

  assign btn = {btn_dec, btn_inc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          sync1, sync2;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          acc;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        state <= RELEASED;
        cnt   <= '0;
      end else begin
        sync1 <= btn[gi];
        sync2 <= sync1;
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      acc       = 1'b0;
      case (state)
        RELEASED: begin
          if (sync2) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else if (cnt >= LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            acc       = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        HELD: begin
          if (!sync2) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (sync2) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt >= LAST) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign accept[gi] = acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= INIT;
      press_inc <= 1'b0;
      press_dec <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      press_inc <= accept[0];
      press_dec <= accept[1];
      ovf       <= 1'b0;
      // simultaneous inc and dec cancel out, and clr wins over any press
      if (clr) begin
        count <= '0;
      end else if (accept[0] && !accept[1]) begin
        if (count == MAX) begin
          ovf <= 1'b1;
`ifdef BUTTON_COUNTER_SAT_EN
          count <= MAX;
`else
          count <= '0;
`endif
        end else begin
          count <= count + WIDTH'(1);
        end
      end else if (accept[1] && !accept[0]) begin
        if (count == '0) begin
          ovf <= 1'b1;
`ifdef BUTTON_COUNTER_SAT_EN
          count <= '0;
`else
          count <= MAX;
`endif
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter: directed scenarios plus random bouncing buttons against a run-length model.
module tb_button_counter;

  localparam int              W    = 8;
  localparam int              D    = 4;
  localparam logic [W-1:0]    INIT = '0;
  localparam logic [W-1:0]    MAXV = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst, btn_inc, btn_dec, clr;
  logic [W-1:0] count;
  logic         press_inc, press_dec, ovf;

  always #5 clk = ~clk;

  button_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .clr(clr),
    .count(count), .press_inc(press_inc), .press_dec(press_dec), .ovf(ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the button is seen two edges late; the accepted level flips once D
  // consecutive samples disagree with it, and a flip to 1 is a press.
  logic [W-1:0] m_count;
  bit           m_pi, m_pd, m_ovf;
  bit           pipe_inc[2], pipe_dec[2];
  bit           lvl_inc, lvl_dec;
  int           run_inc, run_dec;

  task automatic deb(input bit s, inout bit lvl, inout int run, output bit acc);
    acc = 1'b0;
    if (s != lvl) begin
      run++;
      if (run == D) begin
        lvl = s;
        run = 0;
        acc = s;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic step();
    bit si, sd, ai, ad;
    @(posedge clk);
    if (rst) begin
      pipe_inc = '{0, 0};
      pipe_dec = '{0, 0};
      lvl_inc = 0; lvl_dec = 0; run_inc = 0; run_dec = 0;
      m_count = INIT; m_pi = 0; m_pd = 0; m_ovf = 0;
    end else begin
      si = pipe_inc[1]; sd = pipe_dec[1];
      pipe_inc[1] = pipe_inc[0]; pipe_inc[0] = btn_inc;
      pipe_dec[1] = pipe_dec[0]; pipe_dec[0] = btn_dec;
      deb(si, lvl_inc, run_inc, ai);
      deb(sd, lvl_dec, run_dec, ad);
      m_pi = ai; m_pd = ad; m_ovf = 0;
      if (clr) begin
        m_count = '0;
      end else if (ai && !ad) begin
        if (m_count == MAXV) begin
          m_ovf = 1;
`ifndef BUTTON_COUNTER_SAT_EN
          m_count = '0;
`endif
        end else begin
          m_count = m_count + 1'b1;
        end
      end else if (ad && !ai) begin
        if (m_count == '0) begin
          m_ovf = 1;
`ifndef BUTTON_COUNTER_SAT_EN
          m_count = MAXV;
`endif
        end else begin
          m_count = m_count - 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; btn_inc = 0; btn_dec = 0; clr = 0;
    step();
    rst = 0;
  endtask

  task automatic press(input bit inc);
    if (inc) btn_inc = 1; else btn_dec = 1;
    repeat (D + 4) step();
    btn_inc = 0; btn_dec = 0;
    repeat (D + 4) step();
  endtask

  task automatic test_reset();
    rst = 1; btn_inc = 1; btn_dec = 1; clr = 1;
    step();
    step();
    n_checks++;
    if ({count, press_inc, press_dec, ovf} !== {INIT, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d pi=%0b pd=%0b ovf=%0b, required count=%0d pi=0 pd=0 ovf=0",
               count, press_inc, press_dec, ovf, INIT);
    end
    rst = 0; btn_inc = 0; btn_dec = 0; clr = 0;
    repeat (4) step();
    n_checks++;
    if ({count, press_inc, press_dec, ovf} !== {INIT, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_idle: count=%0d pi=%0b pd=%0b ovf=%0b, required count=%0d, no pulses",
               count, press_inc, press_dec, ovf, INIT);
    end
  endtask

  task automatic test_clean_press();
    int first_edge, pulses;
    do_reset();
    btn_inc = 1; first_edge = 0; pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      n_checks++;
      if ({count, press_inc, press_dec, ovf} !== {m_count, m_pi, m_pd, m_ovf}) begin
        n_fail++;
        $display("FAIL clean_press_e%0d: count=%0d pi=%0b pd=%0b ovf=%0b, required count=%0d pi=%0b pd=%0b ovf=%0b",
                 e, count, press_inc, press_dec, ovf, m_count, m_pi, m_pd, m_ovf);
      end
      if (press_inc) begin
        pulses++;
        if (first_edge == 0) first_edge = e;
      end
    end
    n_checks++;
    if (first_edge != D + 2 || pulses != 1 || count !== INIT + 1'b1) begin
      n_fail++;
      $display("FAIL clean_press_latency: edge=%0d pulses=%0d count=%0d, required edge=%0d pulses=1 count=%0d",
               first_edge, pulses, count, D + 2, INIT + 1'b1);
    end
    btn_inc = 0;
    repeat (10) step();
  endtask

  task automatic test_glitch();
    int cyc, hi, lo, seen;
    do_reset();
    cyc = 0; seen = 0;
    while (cyc < 50) begin
      hi = $urandom_range(1, D - 1);
      lo = $urandom_range(1, 4);
      for (int k = 0; k < hi + lo; k++) begin
        btn_inc = (k < hi);
        step();
        n_checks++;
        if ({count, press_inc, press_dec, ovf} !== {m_count, m_pi, m_pd, m_ovf}) begin
          n_fail++;
          $display("FAIL glitch_cycle: count=%0d pi=%0b ovf=%0b, required count=%0d pi=%0b ovf=%0b",
                   count, press_inc, ovf, m_count, m_pi, m_ovf);
        end
        if (press_inc) seen++;
      end
      cyc += hi + lo;
    end
    btn_inc = 0;
    repeat (4) step();
    n_checks++;
    if (count !== 8'd0 || seen != 0) begin
      n_fail++;
      $display("FAIL glitch_reject: count=%0d pulses=%0d, required count=0 pulses=0", count, seen);
    end
  endtask

  task automatic test_limits();
    int ovf_seen;
    logic [W-1:0] exp_val;
    do_reset();
    btn_dec = 1; ovf_seen = 0;
    for (int e = 1; e <= 16; e++) begin
      if (e == 12) btn_dec = 0;
      step();
      n_checks++;
      if ({count, press_inc, press_dec, ovf} !== {m_count, m_pi, m_pd, m_ovf}) begin
        n_fail++;
        $display("FAIL dec_limit_e%0d: count=%0d pd=%0b ovf=%0b, required count=%0d pd=%0b ovf=%0b",
                 e, count, press_dec, ovf, m_count, m_pd, m_ovf);
      end
      if (ovf) ovf_seen++;
    end
`ifdef BUTTON_COUNTER_SAT_EN
    exp_val = 8'd0;
`else
    exp_val = 8'd255;
`endif
    n_checks++;
    if (count !== exp_val || ovf_seen != 1) begin
      n_fail++;
      $display("FAIL dec_at_zero: count=%0d ovf_pulses=%0d, required count=%0d ovf_pulses=1", count, ovf_seen, exp_val);
    end
    for (int i = 0; i < 256 && m_count != MAXV; i++) press(1);
    n_checks++;
    if (count !== 8'd255) begin
      n_fail++;
      $display("FAIL reach_max: count=%0d, required 255", count);
    end
    btn_inc = 1; ovf_seen = 0;
    for (int e = 1; e <= 16; e++) begin
      if (e == 12) btn_inc = 0;
      step();
      n_checks++;
      if ({count, press_inc, press_dec, ovf} !== {m_count, m_pi, m_pd, m_ovf}) begin
        n_fail++;
        $display("FAIL inc_limit_e%0d: count=%0d pi=%0b ovf=%0b, required count=%0d pi=%0b ovf=%0b",
                 e, count, press_inc, ovf, m_count, m_pi, m_ovf);
      end
      if (ovf) ovf_seen++;
    end
`ifdef BUTTON_COUNTER_SAT_EN
    exp_val = 8'd255;
`else
    exp_val = 8'd0;
`endif
    n_checks++;
    if (count !== exp_val || ovf_seen != 1) begin
      n_fail++;
      $display("FAIL inc_at_max: count=%0d ovf_pulses=%0d, required count=%0d ovf_pulses=1", count, ovf_seen, exp_val);
    end
  endtask

  task automatic test_simultaneous();
    int pi_edge, pd_edge, ovf_seen;
    do_reset();
    repeat (10) press(1);
    btn_inc = 1; btn_dec = 1; pi_edge = 0; pd_edge = 0; ovf_seen = 0;
    for (int e = 1; e <= 15; e++) begin
      step();
      n_checks++;
      if ({count, press_inc, press_dec, ovf} !== {m_count, m_pi, m_pd, m_ovf}) begin
        n_fail++;
        $display("FAIL simul_e%0d: count=%0d pi=%0b pd=%0b ovf=%0b, required count=%0d pi=%0b pd=%0b ovf=%0b",
                 e, count, press_inc, press_dec, ovf, m_count, m_pi, m_pd, m_ovf);
      end
      if (press_inc && pi_edge == 0) pi_edge = e;
      if (press_dec && pd_edge == 0) pd_edge = e;
      if (ovf) ovf_seen++;
    end
    n_checks++;
    if (pi_edge != 6 || pd_edge != 6 || count !== 8'd10 || ovf_seen != 0) begin
      n_fail++;
      $display("FAIL simul_press: pi_edge=%0d pd_edge=%0d count=%0d ovf=%0d, required 6 6 10 0",
               pi_edge, pd_edge, count, ovf_seen);
    end
    btn_inc = 0; btn_dec = 0;
    repeat (10) step();
  endtask

  task automatic test_clr();
    do_reset();
    repeat (7) press(1);
    n_checks++;
    if (count !== 8'd7) begin
      n_fail++;
      $display("FAIL clr_setup: count=%0d, required 7", count);
    end
    btn_inc = 1;
    repeat (5) step();
    clr = 1;
    step();
    clr = 0;
    n_checks++;
    if (count !== 8'd0 || press_inc !== 1'b1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_with_press: count=%0d pi=%0b ovf=%0b, required count=0 pi=1 ovf=0", count, press_inc, ovf);
    end
    btn_inc = 0;
    repeat (10) step();
  endtask

  task automatic test_rst_mid();
    int p_edge;
    do_reset();
    btn_inc = 1;
    repeat (3) step();
    rst = 1;
    step();
    rst = 0;
    n_checks++;
    if (count !== INIT || press_inc !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: count=%0d pi=%0b, required count=%0d pi=0", count, press_inc, INIT);
    end
    p_edge = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_checks++;
      if ({count, press_inc, press_dec, ovf} !== {m_count, m_pi, m_pd, m_ovf}) begin
        n_fail++;
        $display("FAIL rst_mid_e%0d: count=%0d pi=%0b, required count=%0d pi=%0b", e, count, press_inc, m_count, m_pi);
      end
      if (press_inc && p_edge == 0) p_edge = e;
    end
    n_checks++;
    if (p_edge != D + 2 || count !== INIT + 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_repress: edge=%0d count=%0d, required edge=%0d count=%0d", p_edge, count, D + 2, INIT + 1'b1);
    end
    btn_inc = 0;
    repeat (10) step();
  endtask

  task automatic test_random();
    int left_inc, left_dec, presses;
    do_reset();
    left_inc = 1; left_dec = 1; presses = 0;
    for (int c = 0; c < 2000; c++) begin
      if (--left_inc == 0) begin btn_inc = ~btn_inc; left_inc = $urandom_range(1, 12); end
      if (--left_dec == 0) begin btn_dec = ~btn_dec; left_dec = $urandom_range(1, 12); end
      clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
      n_checks++;
      if ({count, press_inc, press_dec, ovf} !== {m_count, m_pi, m_pd, m_ovf}) begin
        n_fail++;
        $display("FAIL random_c%0d: count=%0d pi=%0b pd=%0b ovf=%0b, required count=%0d pi=%0b pd=%0b ovf=%0b",
                 c, count, press_inc, press_dec, ovf, m_count, m_pi, m_pd, m_ovf);
      end
      if (m_pi || m_pd) presses++;
    end
    rst = 0; clr = 0; btn_inc = 0; btn_dec = 0;
    n_checks++;
    if (presses == 0) begin
      n_fail++;
      $display("FAIL random_activity: presses=%0d, required at least 1", presses);
    end
  endtask

  initial begin
    rst = 1; btn_inc = 0; btn_dec = 0; clr = 0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_limits();
    test_simultaneous();
    test_clr();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_counter.md
BUTTON_COUNTER -- requirements
Module: button_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; minimum 1.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronised samples needed to accept a level change; minimum 1.
REQ-003 Parameter INIT, default 0, reset value of count, WIDTH bits.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 btn_inc  input  1  raw increment button; asynchronous, may bounce.
REQ-007 btn_dec  input  1  raw decrement button; asynchronous, may bounce.
REQ-008 clr  input  1  synchronous clear of count, in the clk domain.
REQ-009 count  output  WIDTH  current count, registered.
REQ-010 press_inc  output  1  one-cycle pulse per accepted btn_inc press, registered.
REQ-011 press_dec  output  1  one-cycle pulse per accepted btn_dec press, registered.
REQ-012 ovf  output  1  one-cycle pulse when an accepted press hits a counter limit, registered.

Function
REQ-013 Each button SHALL pass through a 2-flop synchroniser; only the second flop's output feeds the debouncer.
REQ-014 Each button SHALL have its own debounce FSM with states RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT and its own stability counter.
REQ-015 RELEASED -> PRESS_WAIT on synced=1; PRESS_WAIT -> RELEASED on synced=0; PRESS_WAIT -> HELD once DEBOUNCE_CYCLES consecutive samples, including the one that entered PRESS_WAIT, are 1.
REQ-016 HELD -> RELEASE_WAIT on synced=0; RELEASE_WAIT -> HELD on synced=1; RELEASE_WAIT -> RELEASED once DEBOUNCE_CYCLES consecutive samples are 0.
REQ-017 When DEBOUNCE_CYCLES=1, PRESS_WAIT and RELEASE_WAIT SHALL last exactly one cycle.
REQ-018 On the edge that enters HELD from PRESS_WAIT, the press pulse SHALL go high for exactly one cycle and count SHALL update on that same edge.
REQ-019 Latency: for a clean press, count SHALL change on rising edge DEBOUNCE_CYCLES+2, where edge 1 is the first edge that samples the button high.
REQ-020 A held button SHALL produce exactly one pulse however long it is held. Bounces shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no release.
REQ-021 An accepted inc SHALL add 1 modulo 2^WIDTH; an accepted dec SHALL subtract 1 modulo 2^WIDTH.
REQ-022 Wrap cases: inc at 2^WIDTH-1 -> 0; dec at 0 -> 2^WIDTH-1. ovf SHALL pulse on the wrapping edge.
REQ-023 Simultaneous inc and dec acceptance on one edge: count SHALL be unchanged; both press pulses SHALL assert; ovf SHALL stay 0.
REQ-024 clr=1: count SHALL load 0 on that edge, overriding any same-edge press; press pulses SHALL still assert; ovf SHALL be 0; debounce FSMs SHALL be unaffected.

Reset
REQ-025 On rst=1 at an edge, the block SHALL apply: count=INIT; press_inc, press_dec, ovf = 0; synchronisers 0; FSMs RELEASED; stability counters 0.
REQ-026 rst SHALL take priority over clr and all presses; a debounce in progress SHALL be aborted.
REQ-027 A button held high across rst deassertion SHALL be re-debounced as a new press and counted once, DEBOUNCE_CYCLES+2 edges after the first post-reset edge.

Configuration
REQ-028 Macro BUTTON_COUNTER_SAT_EN defined: count SHALL saturate. Inc at 2^WIDTH-1 and dec at 0 SHALL leave count unchanged and pulse ovf.
REQ-029 Macro BUTTON_COUNTER_SAT_EN undefined: wrap behaviour per REQ-022 applies.
REQ-030 The simultaneous-press rule (REQ-023) and the clr rule (REQ-024) apply identically with and without the macro.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, INIT=0)
REQ-031 rst, then btn_inc held high 20 cycles -> count=1 at edge 6 exactly; press_inc high exactly 1 cycle; no further change.
REQ-032 btn_inc toggling with 1- to 3-cycle high glitches for 50 cycles -> count stays 0; press_inc never asserts.
REQ-033 count=255, clean inc -> count=0 with ovf pulse; with BUTTON_COUNTER_SAT_EN -> count=255 with ovf pulse. count=0, clean dec -> 255 (wrap) or 0 (sat), ovf pulse in both cases.
REQ-034 count=10, btn_inc and btn_dec rise on the same edge -> both pulses on edge 6; count stays 10; ovf=0.
REQ-035 count=7, clr asserted on the same edge as an accepted inc -> count=0; press_inc=1.
REQ-036 btn_inc held; rst pulsed 1 cycle at edge 4 mid-debounce -> count=INIT; then count=1 exactly 6 edges after the first post-reset edge.
